vx_nc_mem_sched: RTL and testbench

//  Shares the cache's single memory request port between cache fill/writeback traffic and
//  non-cacheable (NC) core requests. Cache traffic has default priority; a starvation guard

---
 rtl/vx_nc_mem_sched.sv | 182 ++++++++++++++++++
 tb/tb_vx_nc_mem_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_nc_mem_sched.sv
// Memory request scheduler: shares one registered memory request port between cache
// fill/writeback traffic and round-robin non-cacheable lanes, with a starvation guard
// for NC traffic and a credit limit on outstanding NC reads.
module vx_nc_mem_sched #(
    parameter int unsigned NUM_REQS        = 4,
    parameter int unsigned ADDR_WIDTH      = 26,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned CORE_TAG_WIDTH  = 8,
    parameter int unsigned CACHE_TAG_WIDTH = 10,
    parameter int unsigned MAX_PENDING     = 4,
    parameter int unsigned STARVE_LIMIT    = 8,
    localparam int unsigned LANE_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int unsigned TAG_OUT_W = 1 + ((CACHE_TAG_WIDTH > CORE_TAG_WIDTH + LANE_W) ?
                                             CACHE_TAG_WIDTH : CORE_TAG_WIDTH + LANE_W),
    localparam int unsigned PEND_W    = $clog2(MAX_PENDING + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cache_req_valid,
    input  logic                                cache_req_rw,
    input  logic [ADDR_WIDTH-1:0]               cache_req_addr,
    input  logic [DATA_WIDTH/8-1:0]             cache_req_byteen,
    input  logic [DATA_WIDTH-1:0]               cache_req_data,
    input  logic [CACHE_TAG_WIDTH-1:0]          cache_req_tag,
    output logic                                cache_req_ready,
    input  logic [NUM_REQS-1:0]                 nc_req_valid,
    input  logic [NUM_REQS-1:0]                 nc_req_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]      nc_req_addr,
    input  logic [NUM_REQS*DATA_WIDTH/8-1:0]    nc_req_byteen,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]      nc_req_data,
    input  logic [NUM_REQS*CORE_TAG_WIDTH-1:0]  nc_req_tag,
    output logic [NUM_REQS-1:0]                 nc_req_ready,
    output logic                                mem_req_valid,
    output logic                                mem_req_rw,
    output logic [ADDR_WIDTH-1:0]               mem_req_addr,
    output logic [DATA_WIDTH/8-1:0]             mem_req_byteen,
    output logic [DATA_WIDTH-1:0]               mem_req_data,
    output logic [TAG_OUT_W-1:0]                mem_req_tag,
    input  logic                                mem_req_ready,
    input  logic                                nc_rsp_fire,
    output logic [PEND_W-1:0]                   nc_pending,
    output logic                                nc_credit_err
);

    localparam int unsigned BYTEEN_W = DATA_WIDTH / 8;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BODY_W   = TAG_OUT_W - 1;

    logic                  load_en, can_read, nc_any, starved;
    logic                  nc_win, cache_win, nc_rd_grant, found;
    logic [NUM_REQS-1:0]   nc_elig;
    logic [LANE_W-1:0]     nc_lane, scan_idx;
    logic [LANE_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [PEND_W-1:0]     pend_q, pend_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d, rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BYTEEN_W-1:0]   byteen_q, byteen_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TAG_OUT_W-1:0]  tag_q, tag_d;

    // Output stage accepts a new request when empty or draining this cycle.
    assign load_en   = ~valid_q | mem_req_ready;
    assign can_read  = pend_q < PEND_W'(MAX_PENDING);
    // Writes never consume a credit, so they stay eligible when reads are throttled.
    assign nc_elig   = nc_req_valid & (nc_req_rw | {NUM_REQS{can_read}});
    assign nc_any    = |nc_elig;
    assign starved   = (starve_q == STARVE_W'(STARVE_LIMIT));
    assign nc_win    = load_en & nc_any & (starved | ~cache_req_valid);
    assign cache_win = load_en & cache_req_valid & ~(starved & nc_any);
    assign nc_rd_grant = nc_win & ~nc_req_rw[nc_lane];

    assign cache_req_ready = cache_win;
    assign nc_req_ready    = nc_win ? (NUM_REQS'(1) << nc_lane) : '0;

    // Round-robin pick: first eligible lane at or after rr_ptr, wrapping.
    always_comb begin
        nc_lane  = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int k = 0; k < int'(NUM_REQS); k++) begin
            scan_idx = LANE_W'((int'(rr_ptr_q) + k) % int'(NUM_REQS));
            if (!found && nc_elig[scan_idx]) begin
                found   = 1'b1;
                nc_lane = scan_idx;
            end
        end
    end

    // Arbitration state: round-robin pointer, starvation counter, read credits.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        starve_d = starve_q;
        pend_d   = pend_q;
        err_d    = err_q;
        if (nc_win) begin
            rr_ptr_d = LANE_W'((int'(nc_lane) + 1) % int'(NUM_REQS));
        end
        if (load_en) begin
            if (nc_win || !nc_any) begin
                starve_d = '0;
            end else if (cache_win && !starved) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end
        if (nc_rd_grant && !nc_rsp_fire) begin
            pend_d = pend_q + PEND_W'(1);
        end else if (nc_rsp_fire && !nc_rd_grant) begin
            // A response with no outstanding read is a protocol error; count stays at zero.
            if (pend_q == '0) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q - PEND_W'(1);
            end
        end
    end

    // Output register next state: load the winner's payload; hold while stalled.
    always_comb begin
        valid_d  = valid_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        byteen_d = byteen_q;
        data_d   = data_q;
        tag_d    = tag_q;
        if (load_en) begin
            valid_d = cache_win | nc_win;
            if (cache_win) begin
                rw_d     = cache_req_rw;
                addr_d   = cache_req_addr;
                byteen_d = cache_req_byteen;
                data_d   = cache_req_data;
                tag_d    = {1'b0, BODY_W'(cache_req_tag)};
            end else if (nc_win) begin
                rw_d     = nc_req_rw[nc_lane];
                addr_d   = nc_req_addr[int'(nc_lane)*ADDR_WIDTH +: ADDR_WIDTH];
                byteen_d = nc_req_byteen[int'(nc_lane)*BYTEEN_W +: BYTEEN_W];
                data_d   = nc_req_data[int'(nc_lane)*DATA_WIDTH +: DATA_WIDTH];
                tag_d    = {1'b1, BODY_W'({nc_lane,
                            nc_req_tag[int'(nc_lane)*CORE_TAG_WIDTH +: CORE_TAG_WIDTH]})};
            end
        end
    end

    // State registers with synchronous reset; reset drops any pending request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            starve_q <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            byteen_q <= '0;
            data_q   <= '0;
            tag_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            starve_q <= starve_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            byteen_q <= byteen_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
        end
    end

    assign mem_req_valid  = valid_q;
    assign mem_req_rw     = rw_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_byteen = byteen_q;
    assign mem_req_data   = data_q;
    assign mem_req_tag    = tag_q;
    assign nc_pending     = pend_q;
    assign nc_credit_err  = err_q;

endmodule

// File: tb/tb_vx_nc_mem_sched.sv
// Self-checking bench for vx_nc_mem_sched: vector table, directed corner sequences and
// randomized traffic checked against a behavioural scheduler model.
module tb_vx_nc_mem_sched;
    localparam int NR = 4, AW = 26, DW = 64, CTW = 8, KTW = 10, MP = 4, SL = 8;
    localparam int BW = DW / 8, TW = 11, PW = 3;
    localparam logic [AW-1:0] CADDR = 26'h1abcdef;

    logic              clk = 1'b0;
    logic              reset;
    logic              cache_req_valid, cache_req_rw, cache_req_ready;
    logic [AW-1:0]     cache_req_addr;
    logic [BW-1:0]     cache_req_byteen;
    logic [DW-1:0]     cache_req_data;
    logic [KTW-1:0]    cache_req_tag;
    logic [NR-1:0]     nc_req_valid, nc_req_rw, nc_req_ready;
    logic [NR*AW-1:0]  nc_req_addr;
    logic [NR*BW-1:0]  nc_req_byteen;
    logic [NR*DW-1:0]  nc_req_data;
    logic [NR*CTW-1:0] nc_req_tag;
    logic              mem_req_valid, mem_req_rw, mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic [BW-1:0]     mem_req_byteen;
    logic [DW-1:0]     mem_req_data;
    logic [TW-1:0]     mem_req_tag;
    logic              nc_rsp_fire, nc_credit_err;
    logic [PW-1:0]     nc_pending;

    always #5 clk = ~clk;

    vx_nc_mem_sched #(
        .NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CORE_TAG_WIDTH(CTW),
        .CACHE_TAG_WIDTH(KTW), .MAX_PENDING(MP), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .cache_req_valid(cache_req_valid), .cache_req_rw(cache_req_rw),
        .cache_req_addr(cache_req_addr), .cache_req_byteen(cache_req_byteen),
        .cache_req_data(cache_req_data), .cache_req_tag(cache_req_tag),
        .cache_req_ready(cache_req_ready),
        .nc_req_valid(nc_req_valid), .nc_req_rw(nc_req_rw), .nc_req_addr(nc_req_addr),
        .nc_req_byteen(nc_req_byteen), .nc_req_data(nc_req_data), .nc_req_tag(nc_req_tag),
        .nc_req_ready(nc_req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_byteen(mem_req_byteen), .mem_req_data(mem_req_data),
        .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
        .nc_rsp_fire(nc_rsp_fire), .nc_pending(nc_pending), .nc_credit_err(nc_credit_err)
    );

    int n_pass, n_total;

    // Reference model state
    bit            mv, m_rw, err;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_data;
    int            m_tag, pend, rr, starve;
    // Per-cycle decision: w_kind 0 none, 1 cache, 2 NC
    int            w_kind, w_lane;
    bit            w_load, w_any;
    logic          obs_c;
    logic [NR-1:0] obs_n;

    typedef struct {
        bit        cv;
        bit [3:0]  nv;
        bit [3:0]  nrw;
        bit        mr;
        bit        fire;
        bit        ec;
        bit [3:0]  en;
        bit        emv;
        bit [10:0] etag;
        int        epend;
        bit        eerr;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_decide();
        bit [NR-1:0] el;
        for (int i = 0; i < NR; i++) el[i] = nc_req_valid[i] && (nc_req_rw[i] || pend < MP);
        w_any  = |el;
        w_load = !mv || mem_req_ready;
        w_lane = -1;
        w_kind = 0;
        for (int k = 0; k < NR; k++) if (w_lane < 0 && el[(rr + k) % NR]) w_lane = (rr + k) % NR;
        if (w_load) begin
            if (starve == SL && w_any) w_kind = 2;
            else if (cache_req_valid) w_kind = 1;
            else if (w_any) w_kind = 2;
        end
    endtask

    task automatic model_commit();
        bit inc;
        if (reset) begin
            mv = 0; m_rw = 0; m_addr = '0; m_be = '0; m_data = '0; m_tag = 0;
            pend = 0; err = 0; rr = 0; starve = 0;
            return;
        end
        inc = 0;
        if (w_kind == 1) begin
            m_rw = cache_req_rw; m_addr = cache_req_addr; m_be = cache_req_byteen;
            m_data = cache_req_data; m_tag = int'(cache_req_tag);
        end
        if (w_kind == 2) begin
            inc    = !nc_req_rw[w_lane];
            m_rw   = nc_req_rw[w_lane];
            m_addr = nc_req_addr[w_lane*AW +: AW];
            m_be   = nc_req_byteen[w_lane*BW +: BW];
            m_data = nc_req_data[w_lane*DW +: DW];
            m_tag  = 1024 + w_lane * 256 + int'(nc_req_tag[w_lane*CTW +: CTW]);
            rr     = (w_lane + 1) % NR;
        end
        if (w_load) begin
            mv = (w_kind != 0);
            if (w_kind == 2 || !w_any) starve = 0;
            else if (starve < SL) starve++;
        end
        if (inc && !nc_rsp_fire) pend++;
        else if (nc_rsp_fire && !inc) begin
            if (pend == 0) err = 1;
            else pend--;
        end
    endtask

    // One clock: readies checked at the falling edge, registers just after the rising edge.
    task automatic mcycle();
        @(negedge clk);
        model_decide();
        obs_c = cache_req_ready;
        obs_n = nc_req_ready;
        if (!reset) begin
            chk("cache_ready", obs_c, w_kind == 1);
            chk("nc_ready", obs_n, (w_kind == 2) ? (1 << w_lane) : 0);
        end
        @(posedge clk);
        #1;
        model_commit();
        chk("mem_valid", mem_req_valid, mv);
        chk("pending", nc_pending, pend);
        chk("credit_err", nc_credit_err, err);
        if (mv) begin
            chk("tag", mem_req_tag, m_tag);
            chk("addr", mem_req_addr, m_addr);
            chk("data", mem_req_data, m_data);
            chk("byteen", mem_req_byteen, m_be);
            chk("rw", mem_req_rw, m_rw);
        end
    endtask

    task automatic drive_idle();
        cache_req_valid = 0; cache_req_rw = 0; cache_req_addr = '0; cache_req_byteen = '0;
        cache_req_data = '0; cache_req_tag = '0; nc_req_valid = '0; nc_req_rw = '0;
        nc_req_addr = '0; nc_req_byteen = '0; nc_req_data = '0; nc_req_tag = '0;
        mem_req_ready = 1; nc_rsp_fire = 0;
    endtask

    task automatic fixed_payload();
        cache_req_addr = CADDR; cache_req_byteen = 8'hf0; cache_req_data = 64'hcafe_f00d;
        cache_req_tag = 10'h155;
        nc_req_tag = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < NR; i++) begin
            nc_req_addr[i*AW +: AW] = AW'(32'h100 + i);
            nc_req_data[i*DW +: DW] = DW'(64'h5000 + i);
            nc_req_byteen[i*BW +: BW] = BW'(1 << i);
        end
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1;
        mcycle();
        reset = 0;
        fixed_payload();
    endtask

    task automatic rand_drive();
        reset            = ($urandom_range(0, 99) == 0);
        cache_req_valid  = 1'($urandom_range(0, 1));
        cache_req_rw     = 1'($urandom_range(0, 1));
        cache_req_addr   = AW'($urandom);
        cache_req_byteen = BW'($urandom);
        cache_req_data   = {$urandom, $urandom};
        cache_req_tag    = KTW'($urandom);
        nc_req_valid     = NR'($urandom);
        nc_req_rw        = NR'($urandom);
        nc_req_addr      = (NR*AW)'({$urandom, $urandom, $urandom, $urandom});
        nc_req_byteen    = $urandom;
        nc_req_data      = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
        nc_req_tag       = $urandom;
        mem_req_ready    = ($urandom_range(0, 3) != 0);
        nc_rsp_fire      = (pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        tbl[0] = '{0, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 1, 11'h612, 1, 0};
        tbl[1] = '{1, 4'b0000, 4'b0000, 1, 0, 1, 4'b0000, 1, 11'h155, 1, 0};
        tbl[2] = '{0, 4'b1111, 4'b1111, 1, 0, 0, 4'b1000, 1, 11'h713, 1, 0};
        tbl[3] = '{0, 4'b1111, 4'b1111, 1, 0, 0, 4'b0001, 1, 11'h410, 1, 0};
        tbl[4] = '{1, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 1, 11'h410, 1, 0};
        tbl[5] = '{0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 1, 11'h410, 0, 0};
        tbl[6] = '{0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 1, 11'h410, 0, 1};
        tbl[7] = '{0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 11'h000, 0, 1};
        tbl[8] = '{1, 4'b0010, 4'b0000, 1, 0, 1, 4'b0000, 1, 11'h155, 0, 1};
        tbl[9] = '{0, 4'b0010, 4'b0000, 1, 0, 0, 4'b0010, 1, 11'h511, 1, 1};

        // Reset state
        drive_idle();
        reset = 1;
        mcycle();
        mcycle();
        chk("rst_valid", mem_req_valid, 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_data", mem_req_data, 0);
        chk("rst_tag", mem_req_tag, 0);
        chk("rst_pending", nc_pending, 0);
        chk("rst_err", nc_credit_err, 0);
        reset = 0;
        fixed_payload();

        // Vector table
        for (int i = 0; i < 10; i++) begin
            cache_req_valid = tbl[i].cv; nc_req_valid = tbl[i].nv; nc_req_rw = tbl[i].nrw;
            mem_req_ready = tbl[i].mr; nc_rsp_fire = tbl[i].fire;
            mcycle();
            chk($sformatf("tbl%0d cache_ready", i), obs_c, tbl[i].ec);
            chk($sformatf("tbl%0d nc_ready", i), obs_n, tbl[i].en);
            chk($sformatf("tbl%0d mem_valid", i), mem_req_valid, tbl[i].emv);
            if (tbl[i].emv) chk($sformatf("tbl%0d tag", i), mem_req_tag, tbl[i].etag);
            chk($sformatf("tbl%0d pending", i), nc_pending, tbl[i].epend);
            chk($sformatf("tbl%0d err", i), nc_credit_err, tbl[i].eerr);
        end

        // Round robin across all lanes
        do_reset();
        nc_req_valid = 4'b1111; nc_req_rw = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            mcycle();
            chk($sformatf("rr grant%0d", i), obs_n, 1 << (i % NR));
        end

        // Starvation guard: cache every cycle vs lane 0 write
        do_reset();
        cache_req_valid = 1; nc_req_valid = 4'b0001; nc_req_rw = 4'b0001;
        for (int i = 0; i < 18; i++) begin
            mcycle();
            chk($sformatf("starve cache%0d", i), obs_c, (i % 9) != 8);
            chk($sformatf("starve nc%0d", i), obs_n, ((i % 9) == 8) ? 1 : 0);
        end

        // Read credit limit
        do_reset();
        nc_req_valid = 4'b0001; nc_req_rw = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            mcycle();
            chk($sformatf("credit grant%0d", i), obs_n, (i < 4) ? 1 : 0);
            chk($sformatf("credit pend%0d", i), nc_pending, (i < 4) ? i + 1 : 4);
        end
        nc_rsp_fire = 1;
        mcycle();
        chk("credit return grant", obs_n, 0);
        chk("credit return pend", nc_pending, 3);
        nc_rsp_fire = 0;
        mcycle();
        chk("credit reissue grant", obs_n, 1);
        chk("credit reissue pend", nc_pending, 4);

        // Output stall holds payload and starvation count
        do_reset();
        cache_req_valid = 1; nc_req_valid = 4'b0001; nc_req_rw = 4'b0001;
        repeat (3) mcycle();
        mem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cache_req_addr = AW'($urandom);
            mcycle();
            chk($sformatf("stall cache_rdy%0d", i), obs_c, 0);
            chk($sformatf("stall nc_rdy%0d", i), obs_n, 0);
            chk($sformatf("stall valid%0d", i), mem_req_valid, 1);
            chk($sformatf("stall tag%0d", i), mem_req_tag, 11'h155);
            chk($sformatf("stall addr%0d", i), mem_req_addr, CADDR);
        end
        cache_req_addr = CADDR;
        mem_req_ready = 1;
        for (int i = 0; i < 6; i++) begin
            mcycle();
            chk($sformatf("post-stall cache%0d", i), obs_c, i < 5);
            chk($sformatf("post-stall nc%0d", i), obs_n, (i == 5) ? 1 : 0);
        end

        // Credit underflow is sticky until reset
        do_reset();
        nc_rsp_fire = 1;
        mcycle();
        chk("underflow pend", nc_pending, 0);
        chk("underflow err", nc_credit_err, 1);
        nc_rsp_fire = 0;
        mcycle();
        chk("underflow err sticky", nc_credit_err, 1);
        reset = 1;
        mcycle();
        reset = 0;
        chk("underflow err cleared", nc_credit_err, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_drive();
            mcycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
